// File: rtl/empty_ptr_storage.sv
// rtl/empty_ptr_storage.sv - free-address pool for the data table RAM
// Self-initialising circular FIFO of table addresses with show-ahead output.
package hash_table;
  localparam int TABLE_ADDR_WIDTH = 4;
endpackage

module empty_ptr_storage #(
  parameter int A_WIDTH = hash_table::TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               srst_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic               init_done_o,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0]   FULL_CNT = DEPTH[A_WIDTH:0];
  localparam logic [A_WIDTH-1:0] ONE_A    = 1;
  localparam logic [A_WIDTH:0]   ONE_C    = 1;

  localparam logic [0:0] INIT_S  = 1'b0;
  localparam logic [0:0] READY_S = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [A_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH:0]   free_cnt_q, free_cnt_d;
  logic               init_done_q, init_done_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic [A_WIDTH-1:0] mem_q [DEPTH];
  logic               mem_we;
  logic [A_WIDTH-1:0] mem_waddr;
  logic [A_WIDTH-1:0] mem_wdata;

  logic val;
  logic pop;
  logic add_ok;

  assign val    = (state_q == READY_S) && (free_cnt_q != '0);
  assign pop    = val && next_empty_ptr_rd_ack_i;
  // A simultaneous pop frees a slot, so a full pool can still take the add.
  assign add_ok = (state_q == READY_S) && add_empty_ptr_en_i &&
                  ((free_cnt_q != FULL_CNT) || pop);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    free_cnt_d  = free_cnt_q;
    init_done_d = init_done_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr_q;
    mem_wdata   = add_empty_ptr_i;

    if (srst_i) begin
      state_d     = INIT_S;
      init_cnt_d  = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      free_cnt_d  = '0;
      init_done_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (next_empty_ptr_rd_ack_i && !val) underflow_d = 1'b1;
      if (add_empty_ptr_en_i && !add_ok)   overflow_d  = 1'b1;

      if (state_q == INIT_S) begin
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = init_cnt_q;
        init_cnt_d = init_cnt_q + ONE_A;
        wr_ptr_d   = wr_ptr_q + ONE_A;
        free_cnt_d = free_cnt_q + ONE_C;
        // wr_ptr wraps to 0 and free_cnt reaches DEPTH on the last write.
        if (&init_cnt_q) begin
          state_d     = READY_S;
          init_done_d = 1'b1;
        end
      end else begin
        if (pop) rd_ptr_d = rd_ptr_q + ONE_A;
        if (add_ok) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_A;
        end
        if (add_ok && !pop)      free_cnt_d = free_cnt_q + ONE_C;
        else if (!add_ok && pop) free_cnt_d = free_cnt_q - ONE_C;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= INIT_S;
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      free_cnt_q  <= '0;
      init_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      free_cnt_q  <= free_cnt_d;
      init_done_q <= init_done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign next_empty_ptr_o     = val ? mem_q[rd_ptr_q] : '0;
  assign next_empty_ptr_val_o = val;
  assign init_done_o          = init_done_q;
  assign free_cnt_o           = free_cnt_q;
  assign overflow_o           = overflow_q;
  assign underflow_o          = underflow_q;

endmodule

// File: tb/tb_empty_ptr_storage.sv
// tb/tb_empty_ptr_storage.sv - directed self-checking bench for empty_ptr_storage
module tb_empty_ptr_storage;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       srst_i;
  logic [3:0] add_empty_ptr_i;
  logic       add_empty_ptr_en_i;
  logic [3:0] next_empty_ptr_o;
  logic       next_empty_ptr_val_o;
  logic       next_empty_ptr_rd_ack_i;
  logic       init_done_o;
  logic [4:0] free_cnt_o;
  logic       overflow_o;
  logic       underflow_o;

  int checks   = 0;
  int failures = 0;

  empty_ptr_storage #(.A_WIDTH(4)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .srst_i                 (srst_i),
    .add_empty_ptr_i        (add_empty_ptr_i),
    .add_empty_ptr_en_i     (add_empty_ptr_en_i),
    .next_empty_ptr_o       (next_empty_ptr_o),
    .next_empty_ptr_val_o   (next_empty_ptr_val_o),
    .next_empty_ptr_rd_ack_i(next_empty_ptr_rd_ack_i),
    .init_done_o            (init_done_o),
    .free_cnt_o             (free_cnt_o),
    .overflow_o             (overflow_o),
    .underflow_o            (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    srst_i = 1'b0;
    add_empty_ptr_i = '0;
    add_empty_ptr_en_i = 1'b0;
    next_empty_ptr_rd_ack_i = 1'b0;
    repeat (2) @(negedge clk_i);

    check_val("rst_free", free_cnt_o, 0);
    check_val("rst_val", next_empty_ptr_val_o, 0);
    check_val("rst_done", init_done_o, 0);
    check_val("rst_ptr", next_empty_ptr_o, 0);
    check_val("rst_ovf", overflow_o, 0);
    check_val("rst_unf", underflow_o, 0);

    rst_i = 1'b0;
    repeat (15) step();
    check_val("init_not_done_15", init_done_o, 0);
    check_val("init_val_low", next_empty_ptr_val_o, 0);
    step();
    check_val("init_done_16", init_done_o, 1);
    check_val("init_free", free_cnt_o, 16);
    check_val("init_val", next_empty_ptr_val_o, 1);
    check_val("init_head", next_empty_ptr_o, 0);

    next_empty_ptr_rd_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("pop3_ptr", next_empty_ptr_o, i);
      step();
    end
    check_val("pop3_free", free_cnt_o, 13);
    check_val("pop3_head", next_empty_ptr_o, 3);

    for (int i = 3; i < 16; i++) begin
      check_val("drain_ptr", next_empty_ptr_o, i);
      step();
    end
    check_val("drain_free", free_cnt_o, 0);
    check_val("drain_val", next_empty_ptr_val_o, 0);
    check_val("drain_unf_clear", underflow_o, 0);
    step();
    next_empty_ptr_rd_ack_i = 1'b0;
    check_val("unf_set", underflow_o, 1);

    add_empty_ptr_i = 4'h5;
    add_empty_ptr_en_i = 1'b1;
    check_val("add5_val_before", next_empty_ptr_val_o, 0);
    step();
    add_empty_ptr_en_i = 1'b0;
    check_val("add5_val", next_empty_ptr_val_o, 1);
    check_val("add5_head", next_empty_ptr_o, 5);
    check_val("add5_free", free_cnt_o, 1);

    add_empty_ptr_i = 4'h9;
    add_empty_ptr_en_i = 1'b1;
    next_empty_ptr_rd_ack_i = 1'b1;
    step();
    add_empty_ptr_en_i = 1'b0;
    check_val("swap1_val", next_empty_ptr_val_o, 1);
    check_val("swap1_head", next_empty_ptr_o, 9);
    check_val("swap1_free", free_cnt_o, 1);
    step();
    next_empty_ptr_rd_ack_i = 1'b0;
    check_val("swap1_empty", free_cnt_o, 0);

    add_empty_ptr_en_i = 1'b1;
    for (int i = 6; i < 16; i++) begin
      add_empty_ptr_i = 4'(i);
      step();
    end
    add_empty_ptr_en_i = 1'b0;
    check_val("fill10_free", free_cnt_o, 10);
    check_val("fill10_head", next_empty_ptr_o, 6);

    add_empty_ptr_i = 4'hA;
    add_empty_ptr_en_i = 1'b1;
    next_empty_ptr_rd_ack_i = 1'b1;
    step();
    add_empty_ptr_en_i = 1'b0;
    check_val("addpop_free", free_cnt_o, 10);
    check_val("addpop_head", next_empty_ptr_o, 7);
    for (int i = 7; i < 16; i++) begin
      check_val("fifo_order", next_empty_ptr_o, i);
      step();
    end
    check_val("fifo_last", next_empty_ptr_o, 4'hA);
    step();
    next_empty_ptr_rd_ack_i = 1'b0;
    check_val("fifo_empty", free_cnt_o, 0);

    add_empty_ptr_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      add_empty_ptr_i = 4'(15 - i);
      step();
    end
    check_val("full_free", free_cnt_o, 16);
    check_val("full_ovf_clear", overflow_o, 0);
    add_empty_ptr_i = 4'h3;
    step();
    add_empty_ptr_en_i = 1'b0;
    check_val("ovf_free", free_cnt_o, 16);
    check_val("ovf_set", overflow_o, 1);
    check_val("ovf_head", next_empty_ptr_o, 4'hF);
    step();
    check_val("ovf_sticky", overflow_o, 1);

    add_empty_ptr_en_i = 1'b1;
    next_empty_ptr_rd_ack_i = 1'b1;
    step();
    check_val("full_addpop_free", free_cnt_o, 16);
    check_val("full_addpop_head", next_empty_ptr_o, 4'hE);

    srst_i = 1'b1;
    step();
    srst_i = 1'b0;
    add_empty_ptr_en_i = 1'b0;
    next_empty_ptr_rd_ack_i = 1'b0;
    check_val("srst_ovf", overflow_o, 0);
    check_val("srst_unf", underflow_o, 0);
    check_val("srst_done", init_done_o, 0);
    check_val("srst_free", free_cnt_o, 0);
    check_val("srst_val", next_empty_ptr_val_o, 0);

    add_empty_ptr_i = 4'h7;
    add_empty_ptr_en_i = 1'b1;
    step();
    add_empty_ptr_en_i = 1'b0;
    check_val("init_add_ovf", overflow_o, 1);
    repeat (14) step();
    check_val("reinit_not_done", init_done_o, 0);
    step();
    check_val("reinit_done", init_done_o, 1);
    check_val("reinit_free", free_cnt_o, 16);
    check_val("reinit_ovf_kept", overflow_o, 1);

    next_empty_ptr_rd_ack_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_val("reinit_pool", next_empty_ptr_o, i);
      step();
    end
    next_empty_ptr_rd_ack_i = 1'b0;
    check_val("reinit_drained", free_cnt_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
